// File: rtl/crc_word_unpacker.sv
// crc_word_unpacker: buffers 8/16/32-bit register writes and streams them bytewise to a CRC engine.
// Optional macro CRC_UNPACK_MSB_FIRST_EN adds a per-write msb_first byte-order select.
module crc_word_unpacker #(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [1:0]                     wr_size,
  input  logic [31:0]                    wr_data,
  input  logic                           flush,
`ifdef CRC_UNPACK_MSB_FIRST_EN
  input  logic                           msb_first,
`endif
  output logic                           wr_ready,
  output logic                           byte_valid,
  output logic [7:0]                     byte_data,
  input  logic                           byte_ready,
  output logic [$clog2(4*DEPTH+1)-1:0]   level,
  output logic                           overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(4 * DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  // Each entry keeps its word plus the index of its final byte (0, 1 or 3).
  logic [31:0]   data_q [DEPTH];
  logic [1:0]    last_q [DEPTH];
`ifdef CRC_UNPACK_MSB_FIRST_EN
  logic [DEPTH-1:0] msb_q;
`endif
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] occ;
  logic [1:0]    byte_idx;

  logic          size_ok, wr_fire, wr_drop, rd_fire, head_done, head_msb;
  logic [2:0]    wr_bytes;
  logic [1:0]    wr_last, sel;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_bytes = 3'd0;
    wr_last  = 2'd0;
    case (wr_size)
      2'b00:   begin wr_bytes = 3'd1; wr_last = 2'd0; end
      2'b01:   begin wr_bytes = 3'd2; wr_last = 2'd1; end
      2'b10:   begin wr_bytes = 3'd4; wr_last = 2'd3; end
      default: begin wr_bytes = 3'd0; wr_last = 2'd0; end
    endcase
  end

  assign size_ok    = (wr_size != 2'b11);
  assign wr_ready   = (occ < OCC_FULL);
  assign byte_valid = (occ != '0);
  assign wr_fire    = wr_en & size_ok & wr_ready & ~flush;
  assign wr_drop    = wr_en & size_ok & ~wr_ready & ~flush;
  assign rd_fire    = byte_valid & byte_ready & ~flush;
  assign head_done  = (byte_idx == last_q[rd_ptr]);

`ifdef CRC_UNPACK_MSB_FIRST_EN
  assign head_msb = msb_q[rd_ptr];
`else
  assign head_msb = 1'b0;
`endif

  // MSB-first walks the same index counter backwards from the entry's last byte.
  assign sel = head_msb ? (last_q[rd_ptr] - byte_idx) : byte_idx;

  always_comb begin
    byte_data = 8'd0;
    if (byte_valid) byte_data = data_q[rd_ptr][{sel, 3'b000} +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      byte_idx <= '0;
      level    <= '0;
      overflow <= 1'b0;
`ifdef CRC_UNPACK_MSB_FIRST_EN
      msb_q    <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      byte_idx <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_fire) begin
        data_q[wr_ptr] <= wr_data;
        last_q[wr_ptr] <= wr_last;
`ifdef CRC_UNPACK_MSB_FIRST_EN
        msb_q[wr_ptr]  <= msb_first;
`endif
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (wr_drop) overflow <= 1'b1;
      if (rd_fire) begin
        if (head_done) begin
          byte_idx <= '0;
          rd_ptr   <= ptr_next(rd_ptr);
        end else begin
          byte_idx <= byte_idx + 2'd1;
        end
      end
      occ   <= occ + OW'(wr_fire) - OW'(rd_fire & head_done);
      level <= level + LW'(wr_fire ? wr_bytes : 3'd0) - LW'(rd_fire);
    end
  end
endmodule

// File: tb/tb_crc_word_unpacker.sv
// Self-checking bench for crc_word_unpacker: scoreboard of expected bytes plus directed scenario tasks.
module tb_crc_word_unpacker;
  localparam int DEPTH = 2;
  localparam int LW = $clog2(4 * DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_size = 2'b11;
  logic [31:0]   wr_data = '0;
  logic          flush = 1'b0;
  logic          byte_ready = 1'b0;
`ifdef CRC_UNPACK_MSB_FIRST_EN
  logic          msb_first = 1'b0;
`endif
  logic          wr_ready, byte_valid, overflow;
  logic [7:0]    byte_data;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       stall_pend = 1'b0;
  logic [7:0] stall_data = '0;

  crc_word_unpacker #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_size(wr_size), .wr_data(wr_data),
    .flush(flush),
`ifdef CRC_UNPACK_MSB_FIRST_EN
    .msb_first(msb_first),
`endif
    .wr_ready(wr_ready), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every transfer pops the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (stall_pend && byte_valid) begin
        checks++;
        if (byte_data !== stall_data) begin
          errors++;
          $display("FAIL stall_stable: byte_data=%h required %h", byte_data, stall_data);
        end
      end
      if (byte_valid && byte_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: byte_data=%h emitted with nothing expected", byte_data);
        end else begin
          automatic logic [7:0] e = exp_q.pop_front();
          if (byte_data !== e) begin
            errors++;
            $display("FAIL byte_order: byte_data=%h required %h", byte_data, e);
          end
        end
      end
      if (!byte_valid) begin
        checks++;
        if (byte_data !== 8'd0) begin
          errors++;
          $display("FAIL idle_data: byte_data=%h required 00", byte_data);
        end
      end
      stall_pend = byte_valid && !byte_ready;
      stall_data = byte_data;
    end else begin
      stall_pend = 1'b0;
    end
  end

  // Drives one write cycle; pushes the bytes it should produce when acceptance is expected.
  task automatic do_write(input logic [1:0] size, input logic [31:0] data, input bit accept,
                          input bit msb);
    int n;
    wr_en = 1'b1;
    wr_size = size;
    wr_data = data;
`ifdef CRC_UNPACK_MSB_FIRST_EN
    msb_first = msb;
`endif
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    if (accept)
      for (int i = 0; i < n; i++)
        exp_q.push_back(msb ? data[8*(n-1-i) +: 8] : data[8*i +: 8]);
    @(posedge clk); #1;
    wr_en = 1'b0;
    wr_size = 2'b11;
  endtask

  task automatic drain(output int left);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    left = exp_q.size();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (level !== '0 || byte_valid !== 1'b0 || byte_data !== 8'd0 || overflow !== 1'b0 ||
        wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: level=%0d valid=%b data=%h ovf=%b rdy=%b required 0 0 00 0 1",
               level, byte_valid, byte_data, overflow, wr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word32();
    int left;
    byte_ready = 1'b1;
    do_write(2'b10, 32'h44332211, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (level !== LW'(4 - i)) begin
        errors++;
        $display("FAIL word32_level: step %0d level=%0d required %0d", i, level, 4 - i);
      end
    end
    drain(left);
    checks++;
    if (left !== 0) begin
      errors++;
      $display("FAIL word32_drain: %0d bytes left, required 0", left);
    end
  endtask

  task automatic test_overflow();
    int left;
    byte_ready = 1'b0;
    do_write(2'b00, 32'h000000AA, 1'b1, 1'b0);
    do_write(2'b01, 32'h0000BBCC, 1'b1, 1'b0);
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: wr_ready=%b required 0", wr_ready);
    end
    do_write(2'b11, 32'h000000EE, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b0 || level !== LW'(3)) begin
      errors++;
      $display("FAIL nowrite_size: overflow=%b level=%0d required 0 3", overflow, level);
    end
    do_write(2'b00, 32'h000000DD, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || level !== LW'(3) || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow_set: overflow=%b level=%0d rdy=%b required 1 3 0",
               overflow, level, wr_ready);
    end
    byte_ready = 1'b1;
    drain(left);
    checks++;
    if (left !== 0 || level !== '0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drain: left=%0d level=%0d overflow=%b required 0 0 1",
               left, level, overflow);
    end
    byte_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: overflow=%b required 0", overflow);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    byte_ready = 1'b0;
    do_write(2'b10, 32'hA1B2C3D4, 1'b1, 1'b0);
    while (exp_q.size() != 0 && n < 30) begin
      byte_ready = ~byte_ready;
      @(posedge clk); #1;
      n++;
    end
    byte_ready = 1'b0;
    checks++;
    if (exp_q.size() !== 0 || level !== '0 || byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: left=%0d level=%0d valid=%b required 0 0 0",
               exp_q.size(), level, byte_valid);
    end
  endtask

  task automatic test_flush();
    byte_ready = 1'b0;
    do_write(2'b10, 32'h01020304, 1'b1, 1'b0);
    do_write(2'b00, 32'h00000005, 1'b1, 1'b0);
    checks++;
    if (level !== LW'(5) || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre: level=%0d rdy=%b required 5 0", level, wr_ready);
    end
    flush = 1'b1;
    wr_en = 1'b1;
    wr_size = 2'b10;
    wr_data = 32'hCAFEF00D;
    byte_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wr_en = 1'b0;
    wr_size = 2'b11;
    exp_q.delete();
    checks++;
    if (level !== '0 || byte_valid !== 1'b0 || overflow !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_post: level=%0d valid=%b ovf=%b rdy=%b required 0 0 0 1",
               level, byte_valid, overflow, wr_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    byte_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int left;
    byte_ready = 1'b1;
    do_write(2'b10, 32'h44332211, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (level !== '0 || byte_valid !== 1'b0 || byte_data !== 8'd0 || overflow !== 1'b0 ||
        wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: level=%0d valid=%b data=%h ovf=%b rdy=%b required 0 0 00 0 1",
               level, byte_valid, byte_data, overflow, wr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_write(2'b00, 32'h00000055, 1'b1, 1'b0);
    checks++;
    if (level !== LW'(1) || byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_write: level=%0d valid=%b required 1 1", level, byte_valid);
    end
    drain(left);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (left !== 0 || level !== '0) begin
      errors++;
      $display("FAIL reset_single: left=%0d level=%0d required 0 0", left, level);
    end
    byte_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int left;
    byte_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_write(2'b00, 32'h60 + i, 1'b1, 1'b0);
      checks++;
      if (level !== LW'(1)) begin
        errors++;
        $display("FAIL b2b_level: write %0d level=%0d required 1", i, level);
      end
    end
    do_write(2'b10, 32'h87654321, 1'b1, 1'b0);
    checks++;
    if (level !== LW'(4)) begin
      errors++;
      $display("FAIL b2b_mixed: level=%0d required 4", level);
    end
    drain(left);
    checks++;
    if (left !== 0 || level !== '0) begin
      errors++;
      $display("FAIL b2b_drain: left=%0d level=%0d required 0 0", left, level);
    end
    byte_ready = 1'b0;
  endtask

`ifdef CRC_UNPACK_MSB_FIRST_EN
  task automatic test_msb_first();
    int left;
    byte_ready = 1'b1;
    do_write(2'b10, 32'h11223344, 1'b1, 1'b1);
    do_write(2'b01, 32'h0000BEEF, 1'b1, 1'b1);
    do_write(2'b01, 32'h00001234, 1'b1, 1'b0);
    drain(left);
    checks++;
    if (left !== 0 || level !== '0) begin
      errors++;
      $display("FAIL msb_drain: left=%0d level=%0d required 0 0", left, level);
    end
    byte_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_word32();
    test_overflow();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
`ifdef CRC_UNPACK_MSB_FIRST_EN
    test_msb_first();
`endif
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
